// File: rtl/mcp3008_responder.sv
// mcp3008_responder: SPI slave emulating an MCP3008 8-channel ADC.
// All SPI pins are oversampled on clk; nothing is clocked by ad_clk.
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   ad_clk, cs_n,    SPI clock, chip select (active low), master-to-slave data
//   din
//   dout             slave-to-master data, updated after each ad_clk fall
//   ch_data          8 packed sample words, channel n at [n*DATA_W +: DATA_W]
//   conv_done        one-clk pulse when B0 has been driven
//   conv_ch/sgl/data channel, SGL/DIFF bit and word of the last completed conversion
//   busy             high from start bit until the data word has been shifted out
module mcp3008_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ad_clk,
  input  logic                  cs_n,
  input  logic                  din,
  output logic                  dout,
  input  logic [8*DATA_W-1:0]   ch_data,
  output logic                  conv_done,
  output logic [2:0]            conv_ch,
  output logic                  conv_sgl,
  output logic [DATA_W-1:0]     conv_data,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {StIdle, StWaitStart, StCfg, StNullb, StData, StTail} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ad_sync_q, ad_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   ad_prev_q, ad_prev_d;
  logic                   armed_q, armed_d;
  logic [2:0]             cfg_q, cfg_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]      word_q, word_d;
  logic [2:0]             cur_ch_q, cur_ch_d;
  logic                   cur_sgl_q, cur_sgl_d;
  logic                   dout_q, dout_d;
  logic                   conv_done_q, conv_done_d;
  logic [2:0]             conv_ch_q, conv_ch_d;
  logic                   conv_sgl_q, conv_sgl_d;
  logic [DATA_W-1:0]      conv_data_q, conv_data_d;

  logic              ad_s, cs_s, din_s, rise, fall;
  logic [2:0]        sel_plus, sel_minus;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] ch_arr [8];

  for (genvar g = 0; g < 8; g++) begin : g_ch
    assign ch_arr[g] = ch_data[g*DATA_W +: DATA_W];
  end

  assign ad_s  = ad_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];
  // prev holds the previous value of the last tap, so rise and fall are mutually exclusive
  assign rise  = ad_s & ~ad_prev_q;
  assign fall  = ~ad_s & ad_prev_q;

  // Result is evaluated with din_s standing in for D0, valid on the D0 rise.
  assign sel_plus  = {cfg_q[1:0], din_s};
  assign sel_minus = {cfg_q[1:0], ~din_s};
  assign diff      = {1'b0, ch_arr[sel_plus]} - {1'b0, ch_arr[sel_minus]};
  assign result    = cfg_q[2] ? ch_arr[sel_plus] : (diff[DATA_W] ? '0 : diff[DATA_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ad_sync_q   <= '0;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      fill_q      <= '0;
      ad_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      cfg_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      cur_ch_q    <= '0;
      cur_sgl_q   <= 1'b0;
      dout_q      <= 1'b0;
      conv_done_q <= 1'b0;
      conv_ch_q   <= '0;
      conv_sgl_q  <= 1'b0;
      conv_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ad_sync_q   <= ad_sync_d;
      cs_sync_q   <= cs_sync_d;
      din_sync_q  <= din_sync_d;
      fill_q      <= fill_d;
      ad_prev_q   <= ad_prev_d;
      armed_q     <= armed_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      cur_ch_q    <= cur_ch_d;
      cur_sgl_q   <= cur_sgl_d;
      dout_q      <= dout_d;
      conv_done_q <= conv_done_d;
      conv_ch_q   <= conv_ch_d;
      conv_sgl_q  <= conv_sgl_d;
      conv_data_q <= conv_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:      if (armed_q) state_d = StWaitStart;
        StWaitStart: if (rise && din_s) state_d = StCfg;
        StCfg:       if (rise && cnt_q == CntW'(3)) state_d = StNullb;
        StNullb:     if (fall) state_d = StData;
        StData:      if (fall && cnt_q == CntW'(DATA_W - 1)) state_d = StTail;
        StTail:      state_d = StTail;
        default:     state_d = StIdle;
      endcase
    end
  end

  // Synchronizers and datapath.
  always_comb begin
    ad_sync_d   = {ad_sync_q[SYNC_STAGES-2:0], ad_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    ad_prev_d   = ad_s;
    // cs_n only counts as deasserted once the sync chain holds real pin samples,
    // so a frame already running at reset release is never joined.
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    cfg_d       = cfg_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    cur_ch_d    = cur_ch_q;
    cur_sgl_d   = cur_sgl_q;
    dout_d      = dout_q;
    conv_done_d = 1'b0;
    conv_ch_d   = conv_ch_q;
    conv_sgl_d  = conv_sgl_q;
    conv_data_d = conv_data_q;
    if (cs_s) begin
      dout_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: dout_d = 1'b0;
        StWaitStart: if (rise && din_s) cnt_d = '0;
        StCfg: begin
          if (rise) begin
            cfg_d = {cfg_q[1:0], din_s};
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(3)) begin
              word_d    = result;
              cur_ch_d  = sel_plus;
              cur_sgl_d = cfg_q[2];
            end
          end
        end
        StNullb: begin
          if (fall) begin
            dout_d = 1'b0;
            cnt_d  = '0;
          end
        end
        StData: begin
          if (fall) begin
            dout_d = word_q[CntW'(DATA_W - 1) - cnt_q];
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(DATA_W - 1)) begin
              conv_done_d = 1'b1;
              conv_ch_d   = cur_ch_q;
              conv_sgl_d  = cur_sgl_q;
              conv_data_d = word_q;
            end
          end
        end
        StTail: if (fall) dout_d = 1'b0;
        default: dout_d = 1'b0;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    dout      = dout_q;
    conv_done = conv_done_q;
    conv_ch   = conv_ch_q;
    conv_sgl  = conv_sgl_q;
    conv_data = conv_data_q;
    busy      = (state_q == StCfg) || (state_q == StNullb) || (state_q == StData);
  end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed + randomized bench for mcp3008_responder acting as SPI master.
module tb_mcp3008_responder;
  localparam int SS   = 2;
  localparam int DW   = 10;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst_n, ad_clk, cs_n, din, dout;
  logic [8*DW-1:0] ch_data;
  logic          conv_done, conv_sgl, busy;
  logic [2:0]    conv_ch;
  logic [DW-1:0] conv_data;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   ch_vals[8];
  logic miso[64];
  logic busy_mid, busy_end;
  int   hook_kind  = 0;
  int   hook_cycle = -1;

  mcp3008_responder #(.SYNC_STAGES(SS), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .cs_n(cs_n), .din(din), .dout(dout),
    .ch_data(ch_data), .conv_done(conv_done), .conv_ch(conv_ch), .conv_sgl(conv_sgl),
    .conv_data(conv_data), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (conv_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < 8; i++) ch_data[i*DW +: DW] = DW'(ch_vals[i]);
  endtask

  // Reference: single-ended returns the channel; differential returns
  // max(0, ch[2P+D0] - ch[2P+~D0]), and 2P+~D0 is just ch with bit 0 flipped.
  function automatic int model(input bit sgl, input bit [2:0] ch);
    int d;
    if (sgl) return ch_vals[ch];
    d = ch_vals[ch] - ch_vals[ch ^ 3'd1];
    return (d < 0) ? 0 : d;
  endfunction

  // One frame: 'zeros' leading zeros, start, SGL, D2..D0, then zeros; miso[k] is
  // dout just before the k-th rise, i.e. the bit driven on the previous fall.
  task automatic do_frame(input bit sgl, input bit [2:0] ch, input int zeros, input int ncyc);
    cs_n = 1'b0; din = 1'b0; ad_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < ncyc; k++) begin
      if (k == zeros) din = 1'b1;
      else if (k == zeros + 1) din = sgl;
      else if (k == zeros + 2) din = ch[2];
      else if (k == zeros + 3) din = ch[1];
      else if (k == zeros + 4) din = ch[0];
      else din = 1'b0;
      repeat (HALF) @(negedge clk);
      miso[k] = dout;
      if (k == zeros + 8) busy_mid = busy;
      if (k == ncyc - 1) busy_end = busy;
      if (k == hook_cycle) begin
        if (hook_kind == 1) begin
          ch_vals[2] = 0;
          pack();
        end else if (hook_kind == 2) begin
          cs_n = 1'b1;
          repeat (SS + 1) @(posedge clk);
          #1;
          check("abort_dout", 32'(dout), 0);
          check("abort_busy", 32'(busy), 0);
          repeat (2 * HALF) @(negedge clk);
          return;
        end else if (hook_kind == 3) begin
          rst_n = 1'b0;
          #1;
          check("rst_dout", 32'(dout), 0);
          check("rst_busy", 32'(busy), 0);
          check("rst_conv_done", 32'(conv_done), 0);
          check("rst_conv_ch", 32'(conv_ch), 0);
          check("rst_conv_sgl", 32'(conv_sgl), 0);
          check("rst_conv_data", 32'(conv_data), 0);
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
        end
      end
      ad_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      ad_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1; din = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic run_check(input string tag, input bit sgl, input bit [2:0] ch,
                           input int zeros, input int ncyc);
    int exp, db, tail_ones;
    logic [DW-1:0] w;
    exp = model(sgl, ch);
    db  = done_cnt;
    do_frame(sgl, ch, zeros, ncyc);
    for (int i = 0; i < DW; i++) w[DW-1-i] = miso[zeros + 6 + i];
    tail_ones = 0;
    for (int k = zeros + 16; k < ncyc; k++) if (miso[k] !== 1'b0) tail_ones++;
    check({tag, "_null"}, 32'(miso[zeros + 5]), 0);
    check({tag, "_word"}, 32'(w), exp);
    check({tag, "_tail"}, tail_ones, 0);
    check({tag, "_done"}, done_cnt - db, 1);
    check({tag, "_ch"}, 32'(conv_ch), 32'(ch));
    check({tag, "_sgl"}, 32'(conv_sgl), 32'(sgl));
    check({tag, "_data"}, 32'(conv_data), exp);
    check({tag, "_busy_mid"}, 32'(busy_mid), 1);
    check({tag, "_busy_end"}, 32'(busy_end), 0);
  endtask

  initial begin
    int db, ones, z;
    bit rs;
    bit [2:0] rc;
    rst_n = 1'b0; ad_clk = 1'b0; cs_n = 1'b1; din = 1'b0;
    for (int i = 0; i < 8; i++) ch_vals[i] = 0;
    pack();
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 0);
    check("reset_conv_done", 32'(conv_done), 0);
    check("reset_conv_ch", 32'(conv_ch), 0);
    check("reset_conv_sgl", 32'(conv_sgl), 0);
    check("reset_conv_data", 32'(conv_data), 0);
    check("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) ch_vals[i] = int'($urandom_range(0, 1023));
    ch_vals[5] = 'h2A5;
    pack();
    run_check("sgl5", 1'b1, 3'd5, 7, 32);
    check("sgl5_const", 32'(conv_data), 'h2A5);

    ch_vals[3] = 600; ch_vals[2] = 250; pack();
    run_check("diff3", 1'b0, 3'd3, 7, 32);
    check("diff3_const", 32'(conv_data), 350);
    ch_vals[3] = 250; ch_vals[2] = 600; pack();
    run_check("diff3_sat", 1'b0, 3'd3, 7, 32);
    check("diff3_sat_const", 32'(conv_data), 0);
    run_check("diff2", 1'b0, 3'd2, 7, 32);
    check("diff2_const", 32'(conv_data), 350);

    for (int n = 0; n < 8; n++) ch_vals[n] = n * 100 + 7;
    pack();
    for (int n = 0; n < 8; n++) run_check("scan", 1'b1, 3'(n), 7, 32);

    // Abort after the 4th data bit; conv_* must still describe the ch7 scan frame.
    ch_vals[4] = 'h3FF; pack();
    db = done_cnt;
    hook_kind = 2; hook_cycle = 16;
    do_frame(1'b1, 3'd4, 7, 32);
    hook_kind = 0; hook_cycle = -1;
    check("abort_pre_busy", 32'(busy_mid), 1);
    check("abort_pre_dout", 32'(miso[16]), 1);
    check("abort_no_done", done_cnt - db, 0);
    check("abort_keep_ch", 32'(conv_ch), 7);
    check("abort_keep_data", 32'(conv_data), 707);
    run_check("after_abort", 1'b1, 3'd1, 7, 32);

    // ch2 is cleared mid-DATA; the snapshot value must still be served.
    ch_vals[2] = 'h3FF; pack();
    hook_kind = 1; hook_cycle = 15;
    run_check("snap", 1'b1, 3'd2, 7, 32);
    hook_kind = 0; hook_cycle = -1;
    check("snap_const", 32'(conv_data), 'h3FF);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) ch_vals[i] = int'($urandom_range(0, 1023));
      pack();
      rs = 1'($urandom_range(0, 1));
      rc = 3'($urandom_range(0, 7));
      z  = int'($urandom_range(0, 10));
      run_check("rand", rs, rc, z, z + 20);
    end

    ch_vals[6] = 'h2AA; ch_vals[7] = 'h3FF; pack();
    run_check("pre_rst", 1'b1, 3'd6, 7, 32);
    db = done_cnt;
    hook_kind = 3; hook_cycle = 16;
    do_frame(1'b1, 3'd7, 7, 32);
    hook_kind = 0; hook_cycle = -1;
    ones = 0;
    for (int k = 17; k < 32; k++) if (miso[k] !== 1'b0) ones++;
    check("rst_ignored_done", done_cnt - db, 0);
    check("rst_ignored_busy", 32'(busy_end), 0);
    check("rst_ignored_dout", ones, 0);
    ch_vals[0] = 'h155; pack();
    run_check("post_rst", 1'b1, 3'd0, 7, 32);
    check("post_rst_const", 32'(conv_data), 'h155);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
